spi_mem_ctrl: RTL and testbench

Sequencing FSM for the SPI slave memory datapath: shift register, address latch, 128x8 data memory and the MISO tri-state buffer. Consumes conditioned SCLK edge pulses and chip select. Emits the single-cycle write/load strobes and the output-buffer enable that turn a raw bit stream into address, read and write transactions. Also drives an 8-bit debug vector for the board LEDs.

---
 rtl/spi_mem_ctrl_pkg.sv | 33 +++
 rtl/spi_mem_ctrl_if.sv | 23 ++
 rtl/spi_mem_ctrl_counter.sv | 26 ++
 rtl/spi_mem_ctrl.sv | 97 +++++++++
 tb/tb_spi_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and defaults for the SPI slave memory controller slice.
package spi_mem_pkg;

  localparam int unsigned DEF_ADDR_BITS = 7;
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_CNT_W     = 4;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_GET_ADDR     = 4'd1,
    ST_GOT_ADDR     = 4'd2,
    ST_READ_WAIT    = 4'd3,
    ST_READ_LOAD    = 4'd4,
    ST_READ_SHIFT   = 4'd5,
    ST_WRITE_SHIFT  = 4'd6,
    ST_WRITE_COMMIT = 4'd7,
    ST_DONE         = 4'd8
  } state_t;

  // LED debug vector: state in the upper nibble, bit counter in the lower.
  typedef struct packed {
    logic [3:0] state;
    logic [3:0] cnt;
  } dbg_t;

  function automatic dbg_t pack_dbg(input state_t s, input logic [3:0] c);
    dbg_t d;
    d.state = s;
    d.cnt   = c;
    return d;
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Control bus between the SCLK/CS conditioning front end and the sequencer.
interface spi_mem_ctrl_if;
  logic       cs_n;
  logic       sclk_pos;
  logic       sclk_neg;
  logic       rw_bit;
  logic       addr_we;
  logic       sr_we;
  logic       dm_we;
  logic       miso_oe;
  logic       busy;
  logic [7:0] dbg;

  modport master (
    output cs_n, sclk_pos, sclk_neg, rw_bit,
    input  addr_we, sr_we, dm_we, miso_oe, busy, dbg
  );

  modport slave (
    input  cs_n, sclk_pos, sclk_neg, rw_bit,
    output addr_we, sr_we, dm_we, miso_oe, busy, dbg
  );
endinterface

// File: rtl/spi_mem_ctrl_counter.sv
// Saturating bit counter with a runtime terminal-count limit.
module spi_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic can_inc;

  // Stopping at limit (which always fits in CNT_W) also prevents wrap.
  assign can_inc = inc && !clr && (cnt < limit);
  assign last    = can_inc && ((cnt + CNT_W'(1)) == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (can_inc) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Sequencing FSM for the SPI slave memory datapath; all outputs registered.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned CNT_W     = DEF_CNT_W   // 2**CNT_W > max(ADDR_BITS+1, DATA_BITS)
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mem_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ADDR_LIM = CNT_W'(ADDR_BITS + 1);
  localparam logic [CNT_W-1:0] DATA_LIM = CNT_W'(DATA_BITS);

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, cnt_limit;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic             neg_only;
  logic             addr_we_d, sr_we_d, dm_we_d, miso_oe_d, busy_d;
  logic             addr_we_q, sr_we_q, dm_we_q, miso_oe_q, busy_q;

  spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .cnt   (bit_cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_we_q <= 1'b0;
      sr_we_q   <= 1'b0;
      dm_we_q   <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      addr_we_q <= addr_we_d;
      sr_we_q   <= sr_we_d;
      dm_we_q   <= dm_we_d;
      miso_oe_q <= miso_oe_d;
      busy_q    <= busy_d;
    end
  end

  // cs_n high while busy overrides every transition, including terminal counts.
  always_comb begin
    state_next = state;
    cnt_clr    = (state == ST_IDLE) || (state == ST_GOT_ADDR) || bus.cs_n;
    cnt_inc    = bus.sclk_pos && !bus.cs_n &&
                 ((state == ST_GET_ADDR) || (state == ST_READ_SHIFT) ||
                  (state == ST_WRITE_SHIFT));
    cnt_limit  = (state == ST_GET_ADDR) ? ADDR_LIM : DATA_LIM;
    if (state != ST_IDLE && bus.cs_n) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:         if (!bus.cs_n) state_next = ST_GET_ADDR;
        ST_GET_ADDR:     if (cnt_last) state_next = ST_GOT_ADDR;
        ST_GOT_ADDR:     state_next = bus.rw_bit ? ST_READ_WAIT : ST_WRITE_SHIFT;
        ST_READ_WAIT:    state_next = ST_READ_LOAD;
        ST_READ_LOAD:    state_next = ST_READ_SHIFT;
        ST_READ_SHIFT:   if (cnt_last) state_next = ST_DONE;
        ST_WRITE_SHIFT:  if (cnt_last) state_next = ST_WRITE_COMMIT;
        ST_WRITE_COMMIT: state_next = ST_DONE;
        ST_DONE:         state_next = ST_DONE;
        default:         state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    neg_only  = bus.sclk_neg && !bus.sclk_pos;
    addr_we_d = (state_next == ST_GOT_ADDR);
    sr_we_d   = (state_next == ST_READ_LOAD);
    dm_we_d   = (state_next == ST_WRITE_COMMIT);
    busy_d    = (state_next != ST_IDLE);
    // MISO keeps driving into DONE until the falling edge after the last bit.
    miso_oe_d = (state_next == ST_READ_SHIFT) ||
                ((state_next == ST_DONE) && miso_oe_q && !neg_only);
  end

  assign bus.addr_we = addr_we_q;
  assign bus.sr_we   = sr_we_q;
  assign bus.dm_we   = dm_we_q;
  assign bus.miso_oe = miso_oe_q;
  assign bus.busy    = busy_q;
  assign bus.dbg     = pack_dbg(state, 4'(bit_cnt));

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: write, read, aborts, async reset and noise.
module tb_spi_mem_ctrl;

  logic clk;
  logic rst_n;

  spi_mem_ctrl_if bus ();

  spi_mem_ctrl #(.ADDR_BITS(7), .DATA_BITS(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Strobe activity, sampled on the falling edge.
  int unsigned n_addr = 0, n_sr = 0, n_dm = 0, n_miso = 0, n_ovl = 0;
  int unsigned b_addr, b_sr, b_dm, b_miso, b_ovl;

  always @(negedge clk) begin
    if (bus.addr_we) n_addr <= n_addr + 1;
    if (bus.sr_we)   n_sr   <= n_sr + 1;
    if (bus.dm_we)   n_dm   <= n_dm + 1;
    if (bus.miso_oe) n_miso <= n_miso + 1;
    if ((2'(bus.addr_we) + 2'(bus.sr_we) + 2'(bus.dm_we)) > 2'd1) n_ovl <= n_ovl + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pos_pulse();
    bus.sclk_pos = 1'b1;
    idle(1);
    bus.sclk_pos = 1'b0;
  endtask

  task automatic neg_pulse();
    bus.sclk_neg = 1'b1;
    idle(1);
    bus.sclk_neg = 1'b0;
  endtask

  task automatic send_bit();
    pos_pulse();
    idle(3);
    neg_pulse();
    idle(3);
  endtask

  task automatic snap();
    b_addr = n_addr; b_sr = n_sr; b_dm = n_dm; b_miso = n_miso; b_ovl = n_ovl;
  endtask

  // Leaves the FSM in GOT_ADDR, right after the 8th header rising edge.
  task automatic header_to_got(input logic rw);
    bus.rw_bit = rw;
    bus.cs_n   = 1'b0;
    idle(1);
    repeat (7) send_bit();
    pos_pulse();
  endtask

  task automatic run_write(input string tag);
    snap();
    header_to_got(1'b0);
    check({tag, "_addr_we"}, 8'(bus.addr_we), 8'd1);
    idle(3);
    neg_pulse();
    idle(3);
    repeat (7) send_bit();
    pos_pulse();
    check({tag, "_dm_we"}, 8'(bus.dm_we), 8'd1);
    idle(1);
    check({tag, "_done_dbg"}, bus.dbg, 8'h88);
    bus.cs_n = 1'b1;
    idle(2);
    check({tag, "_idle_dbg"}, bus.dbg, 8'h00);
    check({tag, "_n_dm"}, 8'(n_dm - b_dm), 8'd1);
    check({tag, "_n_addr"}, 8'(n_addr - b_addr), 8'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.cs_n     = 1'b1;
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b0;
    bus.rw_bit   = 1'b0;
    idle(2);
    check("rst_dbg",  bus.dbg, 8'h00);
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_strb", 8'({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_oe}), 8'd0);
    rst_n = 1'b1;
    idle(2);
    check("idle_dbg", bus.dbg, 8'h00);

    // Write frame: addr 7'h15, rw=0, data 8'hA5 (data bits live in the datapath).
    snap();
    bus.rw_bit = 1'b0;
    bus.cs_n   = 1'b0;
    idle(1);
    check("wr_get_addr", bus.dbg, 8'h10);
    check("wr_busy", 8'(bus.busy), 8'd1);
    repeat (7) send_bit();
    check("wr_cnt7", bus.dbg, 8'h17);
    check("wr_addr_we_pre", 8'(bus.addr_we), 8'd0);
    pos_pulse();
    check("wr_addr_we", 8'(bus.addr_we), 8'd1);
    check("wr_got_dbg", bus.dbg, 8'h28);
    idle(1);
    check("wr_addr_we_off", 8'(bus.addr_we), 8'd0);
    check("wr_shift_dbg", bus.dbg, 8'h60);
    idle(2);
    neg_pulse();
    idle(3);
    repeat (7) send_bit();
    check("wr_data7", bus.dbg, 8'h67);
    check("wr_dm_pre", 8'(bus.dm_we), 8'd0);
    pos_pulse();
    check("wr_dm_we", 8'(bus.dm_we), 8'd1);
    check("wr_commit_dbg", bus.dbg, 8'h78);
    idle(1);
    check("wr_dm_off", 8'(bus.dm_we), 8'd0);
    check("wr_done_dbg", bus.dbg, 8'h88);
    send_bit();
    check("wr_done_hold", bus.dbg, 8'h88);
    check("wr_done_busy", 8'(bus.busy), 8'd1);
    bus.cs_n = 1'b1;
    idle(1);
    check("wr_end_busy", 8'(bus.busy), 8'd0);
    check("wr_end_dbg", bus.dbg, 8'h00);
    idle(1);
    check("wr_n_addr", 8'(n_addr - b_addr), 8'd1);
    check("wr_n_dm",   8'(n_dm - b_dm), 8'd1);
    check("wr_n_sr",   8'(n_sr - b_sr), 8'd0);
    check("wr_n_miso", 8'(n_miso - b_miso), 8'd0);

    // Read frame: addr 7'h15, rw=1.
    snap();
    header_to_got(1'b1);
    check("rd_addr_we", 8'(bus.addr_we), 8'd1);
    idle(1);
    check("rd_wait_dbg", bus.dbg, 8'h30);
    check("rd_wait_strb", 8'({bus.addr_we, bus.sr_we, bus.dm_we}), 8'd0);
    idle(1);
    check("rd_sr_we", 8'(bus.sr_we), 8'd1);
    check("rd_load_dbg", bus.dbg, 8'h40);
    idle(1);
    check("rd_sr_off", 8'(bus.sr_we), 8'd0);
    check("rd_miso_on", 8'(bus.miso_oe), 8'd1);
    check("rd_shift_dbg", bus.dbg, 8'h50);
    idle(1);
    neg_pulse();
    idle(3);
    repeat (7) send_bit();
    check("rd_bit7_dbg", bus.dbg, 8'h57);
    check("rd_bit7_miso", 8'(bus.miso_oe), 8'd1);
    pos_pulse();
    check("rd_done_dbg", bus.dbg, 8'h88);
    check("rd_done_miso", 8'(bus.miso_oe), 8'd1);
    idle(2);
    check("rd_miso_hold", 8'(bus.miso_oe), 8'd1);
    neg_pulse();
    check("rd_miso_drop", 8'(bus.miso_oe), 8'd0);
    check("rd_busy_done", 8'(bus.busy), 8'd1);
    bus.cs_n = 1'b1;
    idle(1);
    check("rd_busy_end", 8'(bus.busy), 8'd0);
    idle(1);
    check("rd_n_sr",   8'(n_sr - b_sr), 8'd1);
    check("rd_n_addr", 8'(n_addr - b_addr), 8'd1);
    check("rd_n_dm",   8'(n_dm - b_dm), 8'd0);

    // Abort after 5 data bits of a write.
    snap();
    header_to_got(1'b0);
    idle(3);
    neg_pulse();
    idle(3);
    repeat (5) send_bit();
    check("ab_cnt5", bus.dbg, 8'h65);
    bus.cs_n = 1'b1;
    idle(1);
    check("ab_dbg", bus.dbg, 8'h00);
    check("ab_busy", 8'(bus.busy), 8'd0);
    idle(1);
    check("ab_n_dm", 8'(n_dm - b_dm), 8'd0);

    // cs_n rises together with the 16th rising edge.
    snap();
    header_to_got(1'b0);
    idle(3);
    neg_pulse();
    idle(3);
    repeat (7) send_bit();
    bus.cs_n     = 1'b1;
    bus.sclk_pos = 1'b1;
    idle(1);
    bus.sclk_pos = 1'b0;
    check("sim_dbg", bus.dbg, 8'h00);
    check("sim_dm_we", 8'(bus.dm_we), 8'd0);
    idle(2);
    check("sim_n_dm", 8'(n_dm - b_dm), 8'd0);

    // Async reset in the middle of READ_SHIFT.
    header_to_got(1'b1);
    idle(3);
    check("ar_miso_pre", 8'(bus.miso_oe), 8'd1);
    neg_pulse();
    idle(3);
    repeat (3) send_bit();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_miso", 8'(bus.miso_oe), 8'd0);
    check("ar_busy", 8'(bus.busy), 8'd0);
    check("ar_dbg",  bus.dbg, 8'h00);
    bus.cs_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("ar_idle", bus.dbg, 8'h00);
    run_write("ar_wr");

    // SCLK noise with cs_n high, then a write of 8'h3C to 7'h7F.
    snap();
    repeat (10) begin
      pos_pulse();
      idle(1);
      neg_pulse();
      idle(1);
    end
    check("nz_busy", 8'(bus.busy), 8'd0);
    check("nz_dbg",  bus.dbg, 8'h00);
    check("nz_n_strb", 8'((n_addr - b_addr) + (n_sr - b_sr) + (n_dm - b_dm)), 8'd0);
    run_write("nz_wr");

    check("ovl_total", 8'(n_ovl), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
